// File: rtl/axil_reg_access_ctrl.sv
// ---------------------------------------------------------------------------
// axil_reg_access_ctrl
//   AXI4-Lite slave front end for the register station. AW, W and AR beats are
//   captured into single-entry slots together with the protocol checker's
//   error flag for that beat. A round-robin arbiter hands the one shared
//   register port to the write or the read side, and the result is returned
//   on B or R. At most one transaction per direction is outstanding: a slot
//   is released only when its B/R response has been accepted.
//
// Ports
//   clk_i, rst_ni                    clock, asynchronous active-low reset
//   s_axi_aw*/w*/b*/ar*/r*           AXI4-Lite slave channels
//   err_awrite_i/err_write_i/err_read_i
//                                    checker flags, sampled at the handshake
//   reg_req_o, reg_we_o, reg_addr_o, reg_wdata_o, reg_wstrb_o
//                                    register port request, held until ack
//   reg_ack_i, reg_rdata_i, reg_err_i
//                                    register port completion
// ---------------------------------------------------------------------------
module axil_reg_access_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter bit          ERR_RESP_EN = 1'b0
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  input  logic                      err_awrite_i,
  input  logic                      err_write_i,
  input  logic                      err_read_i,
  output logic                      reg_req_o,
  output logic                      reg_we_o,
  output logic [ADDR_WIDTH-1:0]     reg_addr_o,
  output logic [DATA_WIDTH-1:0]     reg_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   reg_wstrb_o,
  input  logic                      reg_ack_i,
  input  logic [DATA_WIDTH-1:0]     reg_rdata_i,
  input  logic                      reg_err_i
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_WR_RESP = 3'd3,
    ST_RD_RESP = 3'd4
  } state_t;

  state_t                  state_r, state_nxt_s;

  // Slot storage
  logic                    aw_full_r, w_full_r, ar_full_r;
  logic                    aw_err_r, w_err_r, ar_err_r;
  logic [ADDR_WIDTH-1:0]   aw_addr_r, ar_addr_r;
  logic [DATA_WIDTH-1:0]   w_data_r;
  logic [STRB_WIDTH-1:0]   w_strb_r;
  logic                    aw_full_nxt_s, w_full_nxt_s, ar_full_nxt_s;

  // Ready flags are kept as their own registers so they read 0 during reset
  logic                    awready_r, wready_r, arready_r;

  // Response registers
  logic                    bvalid_r, rvalid_r;
  logic [1:0]              bresp_r, rresp_r;
  logic [DATA_WIDTH-1:0]   rdata_r;

  // 1 when the last grant went to the write side
  logic                    rr_last_wr_r;

  logic                    aw_hs_s, w_hs_s, ar_hs_s, b_hs_s, r_hs_s;
  logic                    wr_elig_s, rd_elig_s, wr_err_s;
  logic                    grant_wr_s, grant_rd_s;
  logic                    req_s, wr_sel_s, rd_sel_s;
  logic                    rsp_load_s, rsp_err_s;

  assign aw_hs_s = s_axi_awvalid & awready_r;
  assign w_hs_s  = s_axi_wvalid  & wready_r;
  assign ar_hs_s = s_axi_arvalid & arready_r;
  assign b_hs_s  = bvalid_r & s_axi_bready;
  assign r_hs_s  = rvalid_r & s_axi_rready;

  // A slot empties on its response handshake; it cannot fill in the same
  // cycle because ready is low while it is full.
  assign aw_full_nxt_s = b_hs_s ? 1'b0 : (aw_hs_s ? 1'b1 : aw_full_r);
  assign w_full_nxt_s  = b_hs_s ? 1'b0 : (w_hs_s  ? 1'b1 : w_full_r);
  assign ar_full_nxt_s = r_hs_s ? 1'b0 : (ar_hs_s ? 1'b1 : ar_full_r);

  assign wr_elig_s = aw_full_r & w_full_r;
  assign rd_elig_s = ar_full_r;
  assign wr_err_s  = aw_err_r | w_err_r;

  // On a tie the side that did not win last time is granted
  assign grant_wr_s = (state_r == ST_IDLE) & wr_elig_s & (~rd_elig_s | ~rr_last_wr_r);
  assign grant_rd_s = (state_r == ST_IDLE) & rd_elig_s & ~grant_wr_s;

  // Next-state and register-port control
  always_comb begin
    state_nxt_s = state_r;
    req_s       = 1'b0;
    wr_sel_s    = 1'b0;
    rd_sel_s    = 1'b0;
    rsp_load_s  = 1'b0;
    rsp_err_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_wr_s) begin
          if (wr_err_s) begin
            // Checker already flagged the beat: never touch the registers
            state_nxt_s = ST_WR_RESP;
            rsp_load_s  = 1'b1;
            rsp_err_s   = 1'b1;
          end else begin
            req_s    = 1'b1;
            wr_sel_s = 1'b1;
            if (reg_ack_i) begin
              state_nxt_s = ST_WR_RESP;
              rsp_load_s  = 1'b1;
              rsp_err_s   = reg_err_i;
            end else begin
              state_nxt_s = ST_WR_REQ;
            end
          end
        end else if (grant_rd_s) begin
          if (ar_err_r) begin
            state_nxt_s = ST_RD_RESP;
            rsp_load_s  = 1'b1;
            rsp_err_s   = 1'b1;
          end else begin
            req_s    = 1'b1;
            rd_sel_s = 1'b1;
            if (reg_ack_i) begin
              state_nxt_s = ST_RD_RESP;
              rsp_load_s  = 1'b1;
              rsp_err_s   = reg_err_i;
            end else begin
              state_nxt_s = ST_RD_REQ;
            end
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        req_s    = 1'b1;
        wr_sel_s = 1'b1;
        if (reg_ack_i) begin
          state_nxt_s = ST_WR_RESP;
          rsp_load_s  = 1'b1;
          rsp_err_s   = reg_err_i;
        end else begin
          state_nxt_s = ST_WR_REQ;
        end
      end
      ST_RD_REQ: begin
        req_s    = 1'b1;
        rd_sel_s = 1'b1;
        if (reg_ack_i) begin
          state_nxt_s = ST_RD_RESP;
          rsp_load_s  = 1'b1;
          rsp_err_s   = reg_err_i;
        end else begin
          state_nxt_s = ST_RD_REQ;
        end
      end
      ST_WR_RESP: begin
        if (b_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WR_RESP;
        end
      end
      ST_RD_RESP: begin
        if (r_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RD_RESP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      rr_last_wr_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (grant_wr_s) begin
        rr_last_wr_r <= 1'b1;
      end else if (grant_rd_s) begin
        rr_last_wr_r <= 1'b0;
      end
    end
  end

  // AW/W/AR slots: fill on handshake, release on response handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_full_r <= 1'b0;
      w_full_r  <= 1'b0;
      ar_full_r <= 1'b0;
      aw_err_r  <= 1'b0;
      w_err_r   <= 1'b0;
      ar_err_r  <= 1'b0;
      aw_addr_r <= {ADDR_WIDTH{1'b0}};
      ar_addr_r <= {ADDR_WIDTH{1'b0}};
      w_data_r  <= {DATA_WIDTH{1'b0}};
      w_strb_r  <= {STRB_WIDTH{1'b0}};
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      arready_r <= 1'b0;
    end else begin
      aw_full_r <= aw_full_nxt_s;
      w_full_r  <= w_full_nxt_s;
      ar_full_r <= ar_full_nxt_s;
      awready_r <= ~aw_full_nxt_s;
      wready_r  <= ~w_full_nxt_s;
      arready_r <= ~ar_full_nxt_s;
      if (aw_hs_s) begin
        aw_addr_r <= s_axi_awaddr;
        aw_err_r  <= ERR_RESP_EN & err_awrite_i;
      end
      if (w_hs_s) begin
        w_data_r <= s_axi_wdata;
        w_strb_r <= s_axi_wstrb;
        w_err_r  <= ERR_RESP_EN & err_write_i;
      end
      if (ar_hs_s) begin
        ar_addr_r <= s_axi_araddr;
        ar_err_r  <= ERR_RESP_EN & err_read_i;
      end
    end
  end

  // B/R response registers, loaded on entry to the response state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bvalid_r <= 1'b0;
      rvalid_r <= 1'b0;
      bresp_r  <= RESP_OKAY;
      rresp_r  <= RESP_OKAY;
      rdata_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      bvalid_r <= (state_nxt_s == ST_WR_RESP);
      rvalid_r <= (state_nxt_s == ST_RD_RESP);
      if (rsp_load_s && (state_nxt_s == ST_WR_RESP)) begin
        bresp_r <= rsp_err_s ? RESP_SLVERR : RESP_OKAY;
      end
      if (rsp_load_s && (state_nxt_s == ST_RD_RESP)) begin
        rresp_r <= rsp_err_s ? RESP_SLVERR : RESP_OKAY;
        // An errored read never exposes register data
        rdata_r <= rsp_err_s ? {DATA_WIDTH{1'b0}} : reg_rdata_i;
      end
    end
  end

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_arready = arready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rresp   = rresp_r;
  assign s_axi_rdata   = rdata_r;

  // Register port is decoded from registered state and slots only, so it is
  // glitch-free, zero in reset, and stable for the whole request.
  assign reg_req_o   = req_s;
  assign reg_we_o    = wr_sel_s;
  assign reg_addr_o  = wr_sel_s ? aw_addr_r :
                       (rd_sel_s ? ar_addr_r : {ADDR_WIDTH{1'b0}});
  assign reg_wdata_o = wr_sel_s ? w_data_r : {DATA_WIDTH{1'b0}};
  assign reg_wstrb_o = wr_sel_s ? w_strb_r : {STRB_WIDTH{1'b0}};

endmodule

// File: tb/tb_axil_reg_access_ctrl.sv
module tb_axil_reg_access_ctrl;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_exp_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
  } r_exp_t;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] s_axi_awaddr = 32'h0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata = 32'h0;
  logic [3:0]  s_axi_wstrb = 4'h0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;
  logic [31:0] s_axi_araddr = 32'h0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;
  logic        err_awrite_i = 1'b0;
  logic        err_write_i = 1'b0;
  logic        err_read_i = 1'b0;
  logic        reg_req_o;
  logic        reg_we_o;
  logic [31:0] reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_wstrb_o;
  logic        reg_ack_i = 1'b0;
  logic [31:0] reg_rdata_i = 32'h0;
  logic        reg_err_i = 1'b0;

  reg_exp_t    exp_reg_q[$];
  logic [1:0]  exp_b_q[$];
  r_exp_t      exp_r_q[$];

  int checks = 0;
  int failures = 0;
  int b_count = 0;
  int ack_delay = 0;
  int wait_cnt = 0;
  bit inject_err = 1'b0;

  logic [31:0] aw_addr_v, w_data_v, ar_addr_v;
  logic [3:0]  w_strb_v;
  logic        aerr_v = 1'b0, werr_v = 1'b0, rerr_v = 1'b0;

  axil_reg_access_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .ERR_RESP_EN(1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .err_awrite_i (err_awrite_i),
    .err_write_i  (err_write_i),
    .err_read_i   (err_read_i),
    .reg_req_o    (reg_req_o),
    .reg_we_o     (reg_we_o),
    .reg_addr_o   (reg_addr_o),
    .reg_wdata_o  (reg_wdata_o),
    .reg_wstrb_o  (reg_wstrb_o),
    .reg_ack_i    (reg_ack_i),
    .reg_rdata_i  (reg_rdata_i),
    .reg_err_i    (reg_err_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  function automatic reg_exp_t mk_reg(input logic we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] wstrb);
    reg_exp_t e;
    e.we = we; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb;
    return e;
  endfunction

  function automatic r_exp_t mk_r(input logic [1:0] resp, input logic [31:0] data);
    r_exp_t e;
    e.resp = resp; e.data = data;
    return e;
  endfunction

  // Register slave model plus register-port monitor
  always @(negedge clk) begin : reg_model
    reg_exp_t e;
    if (!rst_ni) begin
      reg_ack_i = 1'b0;
      reg_err_i = 1'b0;
      wait_cnt  = 0;
    end else if (reg_req_o) begin
      if (wait_cnt >= ack_delay) begin
        reg_ack_i   = 1'b1;
        reg_err_i   = inject_err;
        reg_rdata_i = 32'hC0DE_0000 ^ reg_addr_o;
        inject_err  = 1'b0;
        wait_cnt    = 0;
        if (exp_reg_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL reg_unexpected: got req we=%0b addr=%0h with nothing expected", reg_we_o, reg_addr_o);
        end else begin
          e = exp_reg_q.pop_front();
          check("reg_we", {63'd0, reg_we_o}, {63'd0, e.we});
          check("reg_addr", {32'd0, reg_addr_o}, {32'd0, e.addr});
          if (e.we) begin
            check("reg_wdata", {32'd0, reg_wdata_o}, {32'd0, e.wdata});
            check("reg_wstrb", {60'd0, reg_wstrb_o}, {60'd0, e.wstrb});
          end
        end
      end else begin
        reg_ack_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      reg_ack_i = 1'b0;
      reg_err_i = 1'b0;
      wait_cnt  = 0;
    end
  end

  // B channel monitor
  always @(negedge clk) begin : b_monitor
    logic [1:0] e;
    if (rst_ni && s_axi_bvalid && s_axi_bready) begin
      b_count++;
      if (exp_b_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_unexpected: got bresp %0h with nothing expected", s_axi_bresp);
      end else begin
        e = exp_b_q.pop_front();
        check("bresp", {62'd0, s_axi_bresp}, {62'd0, e});
      end
    end
  end

  // R channel monitor
  always @(negedge clk) begin : r_monitor
    r_exp_t e;
    if (rst_ni && s_axi_rvalid && s_axi_rready) begin
      if (exp_r_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL r_unexpected: got rresp %0h rdata %0h with nothing expected", s_axi_rresp, s_axi_rdata);
      end else begin
        e = exp_r_q.pop_front();
        check("rresp", {62'd0, s_axi_rresp}, {62'd0, e.resp});
        check("rdata", {32'd0, s_axi_rdata}, {32'd0, e.data});
      end
    end
  end

  // Present the selected channels; return #1 after the last handshake edge
  task automatic drive(input bit use_aw, input bit use_w, input bit use_ar);
    bit aw_done, w_done, ar_done, aw_hs, w_hs, ar_hs;
    int t;
    aw_done = !use_aw; w_done = !use_w; ar_done = !use_ar;
    s_axi_awaddr = aw_addr_v; err_awrite_i = use_aw ? aerr_v : 1'b0; s_axi_awvalid = use_aw;
    s_axi_wdata = w_data_v; s_axi_wstrb = w_strb_v; err_write_i = use_w ? werr_v : 1'b0; s_axi_wvalid = use_w;
    s_axi_araddr = ar_addr_v; err_read_i = use_ar ? rerr_v : 1'b0; s_axi_arvalid = use_ar;
    t = 0;
    while (!(aw_done && w_done && ar_done) && t < 100) begin
      @(negedge clk);
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      ar_hs = s_axi_arvalid && s_axi_arready;
      @(posedge clk);
      #1;
      if (aw_hs) begin s_axi_awvalid = 1'b0; err_awrite_i = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin s_axi_wvalid = 1'b0;  err_write_i = 1'b0;  w_done = 1'b1;  end
      if (ar_hs) begin s_axi_arvalid = 1'b0; err_read_i = 1'b0;   ar_done = 1'b1; end
      t++;
    end
    if (!(aw_done && w_done && ar_done)) begin
      timeout_fail("drive_handshake");
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_b_q.size() != 0 || exp_r_q.size() != 0 || exp_reg_q.size() != 0 ||
            s_axi_bvalid || s_axi_rvalid || reg_req_o) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) timeout_fail(name);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] t3_aw [3];
    logic [31:0] t3_ar [3];
    logic [31:0] t3_rd [3];
    int          b_before, t;
    t3_aw = '{32'h40, 32'h48, 32'h50};
    t3_ar = '{32'h80, 32'h84, 32'h88};
    t3_rd = '{32'hC0DE_0080, 32'hC0DE_0084, 32'hC0DE_0088};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", {63'd0, s_axi_awready}, 64'd0);
    check("rst_wready",  {63'd0, s_axi_wready},  64'd0);
    check("rst_arready", {63'd0, s_axi_arready}, 64'd0);
    check("rst_bvalid",  {63'd0, s_axi_bvalid},  64'd0);
    check("rst_rvalid",  {63'd0, s_axi_rvalid},  64'd0);
    check("rst_reg_req", {63'd0, reg_req_o},     64'd0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_awready", {63'd0, s_axi_awready}, 64'd1);
    check("post_rst_wready",  {63'd0, s_axi_wready},  64'd1);
    check("post_rst_arready", {63'd0, s_axi_arready}, 64'd1);

    // 1: write with ack in first request cycle, latency N+1 / N+2
    ack_delay = 0;
    aw_addr_v = 32'h10; w_data_v = 32'hA5A5_0001; w_strb_v = 4'hF;
    exp_reg_q.push_back(mk_reg(1'b1, 32'h10, 32'hA5A5_0001, 4'hF));
    exp_b_q.push_back(2'b00);
    drive(1'b1, 1'b1, 1'b0);
    check("t1_req_n1",     {63'd0, reg_req_o},     64'd1);
    check("t1_we_n1",      {63'd0, reg_we_o},      64'd1);
    check("t1_addr_n1",    {32'd0, reg_addr_o},    64'h10);
    check("t1_bvalid_n1",  {63'd0, s_axi_bvalid},  64'd0);
    check("t1_awready_n1", {63'd0, s_axi_awready}, 64'd0);
    @(posedge clk);
    #1;
    check("t1_bvalid_n2", {63'd0, s_axi_bvalid}, 64'd1);
    check("t1_bresp_n2",  {62'd0, s_axi_bresp},  64'd0);
    wait_drain("t1_drain");

    // Plain read with a 2-cycle register wait
    ack_delay = 2;
    ar_addr_v = 32'h20;
    exp_reg_q.push_back(mk_reg(1'b0, 32'h20, 32'h0, 4'h0));
    exp_r_q.push_back(mk_r(2'b00, 32'hC0DE_0020));
    drive(1'b0, 1'b0, 1'b1);
    wait_drain("t1b_drain");

    // 2: W three cycles ahead of AW, exactly one B
    ack_delay = 1;
    b_before = b_count;
    aw_addr_v = 32'h24; w_data_v = 32'h1234_5678; w_strb_v = 4'h3;
    exp_reg_q.push_back(mk_reg(1'b1, 32'h24, 32'h1234_5678, 4'h3));
    exp_b_q.push_back(2'b00);
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t2_wready_held", {63'd0, s_axi_wready}, 64'd0);
      check("t2_no_req",      {63'd0, reg_req_o},    64'd0);
      @(posedge clk);
      #1;
    end
    drive(1'b1, 1'b0, 1'b0);
    wait_drain("t2_drain");
    repeat (5) @(posedge clk);
    #1;
    check("t2_one_b", b_count - b_before, 64'd1);

    // Read whose register access reports an error
    ack_delay = 0;
    ar_addr_v = 32'h30;
    inject_err = 1'b1;
    exp_reg_q.push_back(mk_reg(1'b0, 32'h30, 32'h0, 4'h0));
    exp_r_q.push_back(mk_r(2'b10, 32'h0));
    drive(1'b0, 1'b0, 1'b1);
    wait_drain("t2b_drain");

    // 3: write pair and AR together, last grant was read -> W then R each round
    for (int i = 0; i < 3; i++) begin
      aw_addr_v = t3_aw[i]; w_data_v = 32'h1000_0000 | t3_aw[i]; w_strb_v = 4'hF;
      ar_addr_v = t3_ar[i];
      exp_reg_q.push_back(mk_reg(1'b1, t3_aw[i], 32'h1000_0000 | t3_aw[i], 4'hF));
      exp_reg_q.push_back(mk_reg(1'b0, t3_ar[i], 32'h0, 4'h0));
      exp_b_q.push_back(2'b00);
      exp_r_q.push_back(mk_r(2'b00, t3_rd[i]));
      drive(1'b1, 1'b1, 1'b1);
      wait_drain("t3_drain");
    end

    // Last grant write -> tie now goes to the read first
    aw_addr_v = 32'h60; w_data_v = 32'h0000_0060; w_strb_v = 4'hF;
    exp_reg_q.push_back(mk_reg(1'b1, 32'h60, 32'h0000_0060, 4'hF));
    exp_b_q.push_back(2'b00);
    drive(1'b1, 1'b1, 1'b0);
    wait_drain("t3b_pre_drain");
    aw_addr_v = 32'h54; w_data_v = 32'h0000_0054; w_strb_v = 4'h1;
    ar_addr_v = 32'h58;
    exp_reg_q.push_back(mk_reg(1'b0, 32'h58, 32'h0, 4'h0));
    exp_reg_q.push_back(mk_reg(1'b1, 32'h54, 32'h0000_0054, 4'h1));
    exp_b_q.push_back(2'b00);
    exp_r_q.push_back(mk_r(2'b00, 32'hC0DE_0058));
    drive(1'b1, 1'b1, 1'b1);
    wait_drain("t3b_drain");

    // 4: checker errors bypass the register port
    aw_addr_v = 32'h13; w_data_v = 32'h0000_0013; w_strb_v = 4'hF; aerr_v = 1'b1;
    exp_b_q.push_back(2'b10);
    drive(1'b1, 1'b1, 1'b0);
    aerr_v = 1'b0;
    check("t4_no_req_n1", {63'd0, reg_req_o},    64'd0);
    check("t4_bvalid_n1", {63'd0, s_axi_bvalid}, 64'd0);
    @(posedge clk);
    #1;
    check("t4_no_req_n2", {63'd0, reg_req_o},    64'd0);
    check("t4_bvalid_n2", {63'd0, s_axi_bvalid}, 64'd1);
    wait_drain("t4a_drain");
    ar_addr_v = 32'h17; rerr_v = 1'b1;
    exp_r_q.push_back(mk_r(2'b10, 32'h0));
    drive(1'b0, 1'b0, 1'b1);
    rerr_v = 1'b0;
    wait_drain("t4b_drain");
    aw_addr_v = 32'h18; w_data_v = 32'hDEAD_BEEF; w_strb_v = 4'h0; werr_v = 1'b1;
    exp_b_q.push_back(2'b10);
    drive(1'b1, 1'b1, 1'b0);
    werr_v = 1'b0;
    wait_drain("t4c_drain");

    // 5: B back-pressure keeps response stable and the AW slot closed
    s_axi_bready = 1'b0;
    aw_addr_v = 32'h61; w_data_v = 32'h0000_0061; w_strb_v = 4'hF; aerr_v = 1'b1;
    exp_b_q.push_back(2'b10);
    drive(1'b1, 1'b1, 1'b0);
    aerr_v = 1'b0;
    t = 0;
    while (!s_axi_bvalid && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) timeout_fail("t5_bvalid_wait");
    for (int i = 0; i < 5; i++) begin
      check("t5_bvalid_held",  {63'd0, s_axi_bvalid},  64'd1);
      check("t5_bresp_held",   {62'd0, s_axi_bresp},   64'd2);
      check("t5_awready_low",  {63'd0, s_axi_awready}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    s_axi_bready = 1'b1;
    wait_drain("t5_drain");
    check("t5_awready_back", {63'd0, s_axi_awready}, 64'd1);

    // 6: reset while the register port is busy aborts without a stale response
    ack_delay = 20;
    aw_addr_v = 32'h70; w_data_v = 32'h0000_0070; w_strb_v = 4'hF;
    drive(1'b1, 1'b1, 1'b0);
    check("t6_req_before", {63'd0, reg_req_o}, 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("t6_rst_req",     {63'd0, reg_req_o},     64'd0);
    check("t6_rst_we",      {63'd0, reg_we_o},      64'd0);
    check("t6_rst_addr",    {32'd0, reg_addr_o},    64'd0);
    check("t6_rst_awready", {63'd0, s_axi_awready}, 64'd0);
    check("t6_rst_bvalid",  {63'd0, s_axi_bvalid},  64'd0);
    check("t6_rst_rvalid",  {63'd0, s_axi_rvalid},  64'd0);
    repeat (2) @(posedge clk);
    #1;
    ack_delay = 0;
    b_before = b_count;
    rst_ni = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_bvalid",  {63'd0, s_axi_bvalid},  64'd0);
    check("t6_no_rvalid",  {63'd0, s_axi_rvalid},  64'd0);
    check("t6_no_req",     {63'd0, reg_req_o},     64'd0);
    check("t6_no_b_seen",  b_count - b_before,     64'd0);
    check("t6_awready",    {63'd0, s_axi_awready}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
